// File: rtl/lsu_pkg.sv
// Shared encodings, widths and request record for the load/store unit.
// The optional MISALIGN_TRAP_EN build uses is_bad_req() to reject misaligned or illegal-size requests.
package lsu_pkg;
  localparam int BYTE_ADDR_W = 18;
  localparam int MEM_ADDR_W  = 16;
  localparam int DATA_W      = 32;
  localparam int NUM_LANES   = 4;
  localparam int LANE_W      = 8;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} lsu_state_t;

  typedef struct packed {
    logic              write;
    logic [1:0]        size;
    logic              sign;
    logic [DATA_W-1:0] wdata;
  } lsu_req_t;

  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: is_bad_req = 1'b0;
      SIZE_HALF: is_bad_req = lo[0];
      SIZE_WORD: is_bad_req = (lo != 2'b00);
      default:   is_bad_req = 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/lsu_lane_mux.sv
// Combinational little-endian lane logic: load extract/extend and store merge.
// Any size other than byte/half behaves as a full word.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged
);
  logic [DATA_W-1:0] byte_src, half_src;
  logic [NUM_LANES-1:0][LANE_W-1:0] old_l, new_l, mrg_l;
  logic [NUM_LANES-1:0] be;

  always_comb begin
    byte_src = old_word >> {addr_lo, 3'b000};
    half_src = old_word >> {addr_lo[1], 4'b0000};
    case (size)
      SIZE_BYTE: load_data = {{24{sign_ext & byte_src[7]}}, byte_src[7:0]};
      SIZE_HALF: load_data = {{16{sign_ext & half_src[15]}}, half_src[15:0]};
      default:   load_data = old_word;
    endcase
  end

  // Replicate the store data across the word so each lane just picks old or new.
  assign old_l = old_word;
  assign new_l = (size == SIZE_BYTE) ? {4{wdata[7:0]}} :
                 (size == SIZE_HALF) ? {2{wdata[15:0]}} : wdata;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LANE = 2'(i);
    assign be[i]    = (size == SIZE_BYTE) ? (addr_lo == LANE) :
                      (size == SIZE_HALF) ? (addr_lo[1] == LANE[1]) : 1'b1;
    assign mrg_l[i] = be[i] ? new_l[i] : old_l[i];
  end

  assign merged = mrg_l;
endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory; sub-word stores do read-modify-write.
// Define MISALIGN_TRAP_EN to return resp_error for misaligned / illegal-size requests without touching memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int BYTE_ADDR_W = 18,
  parameter int MEM_ADDR_W  = 16
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [1:0]             req_size,
  input  logic                   req_signed,
  input  logic [BYTE_ADDR_W-1:0] req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_rdata,
  output logic                   resp_error,
  output logic [MEM_ADDR_W-1:0]  mem_address,
  input  logic [31:0]            mem_read_data,
  output logic [31:0]            mem_write_data,
  output logic                   mem_write_enable
);
  lsu_state_t state, state_nxt;
  lsu_req_t   req_q;
  logic [BYTE_ADDR_W-1:0] addr_q;
  logic [31:0] merged_q, load_data, merged;
  logic        req_is_word, req_err;

  assign req_is_word = (req_q.size != SIZE_BYTE) && (req_q.size != SIZE_HALF);

`ifdef MISALIGN_TRAP_EN
  assign req_err = is_bad_req(req_size, req_addr[1:0]);
`else
  assign req_err = 1'b0;
`endif

  lsu_lane_mux u_lane_mux (
    .old_word  (mem_read_data),
    .wdata     (req_q.wdata),
    .addr_lo   (addr_q[1:0]),
    .size      (req_q.size),
    .sign_ext  (req_q.sign),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = req_err ? RESP : ACCESS;
      ACCESS:  state_nxt = (req_q.write && !req_is_word) ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write strobe comes only from registered state, and never fires while reset is held.
  always_comb begin
    req_ready        = (state == IDLE);
    resp_valid       = (state == RESP);
    mem_address      = addr_q[BYTE_ADDR_W-1:2];
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    if (!reset) begin
      case (state)
        ACCESS: if (req_q.write && req_is_word) begin
          mem_write_enable = 1'b1;
          mem_write_data   = req_q.wdata;
        end
        WRITE: begin
          mem_write_enable = 1'b1;
          mem_write_data   = merged_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_q      <= '0;
      addr_q     <= '0;
      merged_q   <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_valid) begin
          req_q      <= '{write: req_write, size: req_size, sign: req_signed, wdata: req_wdata};
          addr_q     <= req_addr;
          resp_rdata <= '0;
          resp_error <= req_err;
        end
        ACCESS: begin
          if (!req_q.write) resp_rdata <= load_data;
          merged_q <= merged;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory; expectations are hand-computed.
// Build with MISALIGN_TRAP_EN defined to exercise the trap expectations in test_misalign.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [17:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_error;
  logic [31:0] resp_rdata;
  logic [15:0] mem_address;
  logic [31:0] mem_read_data, mem_write_data;
  logic        mem_write_enable;

  logic [31:0] mem [0:65535];
  logic        pre_en = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  int n_checks = 0, n_fail = 0;
  int got_lat, wr_seen, wr_lat;
  logic [31:0] got_rdata, wr_data;
  logic        got_err;
  logic [15:0] wr_addr;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_address(mem_address), .mem_read_data(mem_read_data),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address];
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (mem_write_enable) mem[mem_address] <= mem_write_data;
  end

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Issue one request, track write strobes and latency (edges counted from the accepting edge),
  // optionally hold off resp_ready for 'hold' cycles, then complete the handshake.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [17:0] a, input logic [31:0] wd, input int hold);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wr_seen = 0; wr_lat = 0; got_lat = 0; wr_data = '0; wr_addr = '0;
    for (int k = 1; k <= 20; k++) begin
      if (mem_write_enable) begin
        wr_seen++; wr_lat = k; wr_data = mem_write_data; wr_addr = mem_address;
      end
      if (resp_valid) begin got_lat = k; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (got_lat == 0) begin n_fail++; $display("FAIL resp_timeout: resp_valid never rose within 20 cycles"); end
    got_rdata = resp_rdata; got_err = resp_error;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      n_checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== got_rdata || req_ready !== 1'b0 || mem_write_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold[%0d]: valid=%b rdata=%h ready=%b we=%b, required valid=1 rdata=%h ready=0 we=0",
                 h, resp_valid, resp_rdata, req_ready, mem_write_enable, got_rdata);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_resp: ready=%b valid=%b rdata=%h err=%b, required 1 0 0 0", req_ready, resp_valid, resp_rdata, resp_error);
    end
    n_checks++;
    if (mem_write_enable !== 1'b0 || mem_address !== 16'h0 || mem_write_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mem: we=%b addr=%h wdata=%h, required 0 0 0", mem_write_enable, mem_address, mem_write_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_load();
    preload(16'h0001, 32'h8899AABB);
    do_req(1'b0, 2'b00, 1'b1, 18'h00005, 32'h0, 0);
    n_checks++;
    if (got_rdata !== 32'hFFFFFFAA || got_lat != 2 || got_err !== 1'b0) begin
      n_fail++; $display("FAIL load_byte_signed: rdata=%h lat=%0d err=%b, required FFFFFFAA 2 0", got_rdata, got_lat, got_err);
    end
    do_req(1'b0, 2'b00, 1'b0, 18'h00005, 32'h0, 0);
    n_checks++;
    if (got_rdata !== 32'h000000AA || got_lat != 2) begin
      n_fail++; $display("FAIL load_byte_unsigned: rdata=%h lat=%0d, required 000000AA 2", got_rdata, got_lat);
    end
    do_req(1'b0, 2'b01, 1'b1, 18'h00006, 32'h0, 0);
    n_checks++;
    if (got_rdata !== 32'hFFFF8899) begin
      n_fail++; $display("FAIL load_half_hi_signed: rdata=%h, required FFFF8899", got_rdata);
    end
    do_req(1'b0, 2'b01, 1'b1, 18'h00004, 32'h0, 0);
    n_checks++;
    if (got_rdata !== 32'hFFFFAABB) begin
      n_fail++; $display("FAIL load_half_lo_signed: rdata=%h, required FFFFAABB", got_rdata);
    end
    do_req(1'b0, 2'b10, 1'b1, 18'h00004, 32'h0, 0);
    n_checks++;
    if (got_rdata !== 32'h8899AABB || wr_seen != 0) begin
      n_fail++; $display("FAIL load_word: rdata=%h writes=%0d, required 8899AABB 0", got_rdata, wr_seen);
    end
  endtask

  task automatic test_subword_store();
    do_req(1'b1, 2'b01, 1'b0, 18'h00006, 32'h00001234, 0);
    n_checks++;
    if (wr_seen != 1 || wr_lat != 2 || wr_data !== 32'h1234AABB || wr_addr !== 16'h0001) begin
      n_fail++; $display("FAIL half_store_strobe: writes=%0d at=%0d data=%h addr=%h, required 1 2 1234AABB 0001",
                         wr_seen, wr_lat, wr_data, wr_addr);
    end
    n_checks++;
    if (got_lat != 3 || got_rdata !== 32'h0 || mem[1] !== 32'h1234AABB) begin
      n_fail++; $display("FAIL half_store_resp: lat=%0d rdata=%h mem=%h, required 3 0 1234AABB", got_lat, got_rdata, mem[1]);
    end
    do_req(1'b0, 2'b10, 1'b0, 18'h00004, 32'h0, 0);
    n_checks++;
    if (got_rdata !== 32'h1234AABB) begin
      n_fail++; $display("FAIL load_after_half_store: rdata=%h, required 1234AABB", got_rdata);
    end
    do_req(1'b1, 2'b00, 1'b0, 18'h00007, 32'hFFFFFF55, 0);
    n_checks++;
    if (wr_seen != 1 || wr_lat != 2 || wr_data !== 32'h5534AABB || mem[1] !== 32'h5534AABB) begin
      n_fail++; $display("FAIL byte_store_lane3: writes=%0d at=%0d data=%h mem=%h, required 1 2 5534AABB 5534AABB",
                         wr_seen, wr_lat, wr_data, mem[1]);
    end
  endtask

  task automatic test_word_store_top();
    do_req(1'b1, 2'b10, 1'b0, 18'h3FFFC, 32'hDEADBEEF, 0);
    n_checks++;
    if (wr_seen != 1 || wr_lat != 1 || wr_addr !== 16'hFFFF || wr_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL word_store_strobe: writes=%0d at=%0d addr=%h data=%h, required 1 1 FFFF DEADBEEF",
                         wr_seen, wr_lat, wr_addr, wr_data);
    end
    n_checks++;
    if (got_lat != 2 || got_rdata !== 32'h0 || mem[16'hFFFF] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL word_store_resp: lat=%0d rdata=%h mem=%h, required 2 0 DEADBEEF", got_lat, got_rdata, mem[16'hFFFF]);
    end
  endtask

  task automatic test_back_pressure();
    do_req(1'b0, 2'b10, 1'b0, 18'h00004, 32'h0, 5);
    n_checks++;
    if (got_rdata !== 32'h5534AABB || wr_seen != 0) begin
      n_fail++; $display("FAIL backpressure_load: rdata=%h writes=%0d, required 5534AABB 0", got_rdata, wr_seen);
    end
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL after_handshake: ready=%b valid=%b, required 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_reset_in_write();
    preload(16'h0002, 32'h11223344);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 18'h00008; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (mem_write_enable !== 1'b1 || mem_write_data !== 32'h11223377) begin
      n_fail++; $display("FAIL write_cycle_reached: we=%b data=%h, required 1 11223377", mem_write_enable, mem_write_data);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (mem_write_enable !== 1'b0) begin
      n_fail++; $display("FAIL we_gated_by_reset: we=%b, required 0", mem_write_enable);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (mem[2] !== 32'h11223344 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_abort: mem=%h ready=%b valid=%b, required 11223344 1 0", mem[2], req_ready, resp_valid);
    end
  endtask

  task automatic test_misalign();
    do_req(1'b0, 2'b10, 1'b0, 18'h00006, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
    n_checks++;
    if (got_err !== 1'b1 || got_rdata !== 32'h0 || got_lat != 1 || wr_seen != 0) begin
      n_fail++; $display("FAIL misaligned_word_trap: err=%b rdata=%h lat=%0d writes=%0d, required 1 0 1 0",
                         got_err, got_rdata, got_lat, wr_seen);
    end
`else
    n_checks++;
    if (got_err !== 1'b0 || got_rdata !== 32'h5534AABB || got_lat != 2) begin
      n_fail++; $display("FAIL misaligned_word_ignored: err=%b rdata=%h lat=%0d, required 0 5534AABB 2", got_err, got_rdata, got_lat);
    end
`endif
    do_req(1'b0, 2'b11, 1'b0, 18'h00004, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
    n_checks++;
    if (got_err !== 1'b1 || got_rdata !== 32'h0 || got_lat != 1) begin
      n_fail++; $display("FAIL illegal_size_trap: err=%b rdata=%h lat=%0d, required 1 0 1", got_err, got_rdata, got_lat);
    end
`else
    n_checks++;
    if (got_err !== 1'b0 || got_rdata !== 32'h5534AABB || got_lat != 2) begin
      n_fail++; $display("FAIL illegal_size_as_word: err=%b rdata=%h lat=%0d, required 0 5534AABB 2", got_err, got_rdata, got_lat);
    end
`endif
  endtask

  initial begin
    #1;
    test_reset();
    test_load();
    test_subword_store();
    test_word_store_top();
    test_back_pressure();
    test_reset_in_write();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
